cla_4_bit: RTL and testbench
============================

# cla_4_bit

Registered 4-bit carry-lookahead adder slice. Computes A + B + C0 with full two-level lookahead and exports block propagate/generate so several slices can be cascaded under a second-level lookahead unit. It is the leaf arithmetic cell of the hierarchical CLA adders. Results are captured on the clock edge with a synchronous active-low reset.

## Interface
- No parameters; width fixed at 4 bits.
- One clock; reset is synchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- A  input  4  addend, unsigned
- B  input  4  addend, unsigned
- C0  input  1  carry-in
- S  output  4  registered sum bits
- C4  output  1  registered carry-out
- P_block  output  1  registered block propagate
- G_block  output  1  registered block generate
- OVF  output  1  registered signed overflow; present only with CLA_4_BIT_OVF_EN

## Operation
- Bit terms: Pi = Ai ^ Bi, Gi = Ai & Bi, for i = 0..3.
- Carries are flat lookahead, not rippled:
  - C1 = G0 | P0C0
  - C2 = G1 | P1G0 | P1P0C0
  - C3 = G2 | P2G1 | P2P1G0 | P2P1P0C0
- Si = Pi ^ Ci.
- P_block = P3P2P1P0.
- G_block = G3 | P3G2 | P3P2G1 | P3P2P1G0.
- P_block and G_block never depend on C0.
- C4 = G_block | (P_block & C0).
- {C4,S} equals A + B + C0 exactly, range 0..31. No saturation; wrap is visible as C4=1.
- All outputs are flops updated every cycle; there is no enable and no handshake.

## Timing
- Latency 1 cycle: inputs sampled at rising edge N appear on the outputs after edge N. Throughput is one add per cycle.
- rst_n low at an edge: all outputs (S, C4, P_block, G_block, OVF) become 0 at that edge, regardless of A/B/C0.
- Reset mid-stream: the in-flight result is discarded. The first valid result appears one edge after the edge where rst_n is sampled high.
- Inputs must be stable for the setup window around each edge; the combinational path is A/B/C0 to flop D only.

## Configuration
- Macro CLA_4_BIT_OVF_EN.
- Defined: adds output OVF, registered, reset to 0, with OVF = C4 ^ C3 (two's-complement overflow of the 4-bit signed add).
- Undefined: the OVF port and its flop do not exist; all other behaviour is identical.

## Structure
- Shared package cla_pkg holds:
  - CLA_W = 4
  - the typedef for a 4-bit operand
  - a function computing (P_block, G_block) from 4-bit P/G vectors, reused by the second-level lookahead unit
- One sub-module, cla_pg_cell: 1-bit Pi/Gi generator, instantiated 4 times.
- The lookahead carry logic and output register stay in the top module.

## Test plan
- A=3, B=5, C0=0 -> next cycle S=8, C4=0, P_block=0, G_block=0.
- A=7, B=9, C0=0 -> S=0, C4=1, P_block=0, G_block=1. A=15, B=1, C0=0 gives the same result.
- A=4, B=6, C0=1 -> S=11, C4=0. A=8, B=8, C0=1 -> S=1, C4=1, G_block=1, P_block=0.
- A=15, B=0, C0=1 -> S=0, C4=1, P_block=1, G_block=0. Same A/B with C0=0 -> S=15, C4=0, P_block=1.
- Apply A=15, B=15, C0=1, and assert rst_n=0 in the same cycle -> all outputs 0. Deassert rst_n -> next edge S=15, C4=1.
- Exhaustive sweep of 512 combinations against A+B+C0, each checked one cycle later. With CLA_4_BIT_OVF_EN: A=7, B=1 -> OVF=1; A=8, B=8 -> OVF=1; A=3, B=5 -> OVF=1; A=2, B=1 -> OVF=0.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the hierarchical carry-lookahead adders.
// Block propagate/generate helper is reused by the second-level lookahead unit.
package cla_pkg;

    localparam int unsigned CLA_W = 4;

    typedef logic [CLA_W-1:0] cla_operand_t;

    typedef struct packed {
        logic p_block;
        logic g_block;
    } cla_block_pg_t;

    function automatic cla_block_pg_t cla_block_pg(input logic [CLA_W-1:0] p,
                                                   input logic [CLA_W-1:0] g);
        cla_block_pg_t r;
        r.p_block = &p;
        r.g_block = g[3]
                  | (p[3] & g[2])
                  | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_pg_cell.sv
// Single-bit propagate/generate term generator for the lookahead adders.
module cla_pg_cell (
    input  logic a,
    input  logic b,
    output logic p,
    output logic g
);

    always_comb begin
        p = a ^ b;
        g = a & b;
    end

endmodule

// File: rtl/cla_4_bit.sv
// Registered 4-bit carry-lookahead adder slice with block P/G export.
// Define CLA_4_BIT_OVF_EN to add the registered signed-overflow output OVF.
module cla_4_bit
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CLA_W-1:0] A,
    input  logic [CLA_W-1:0] B,
    input  logic             C0,
    output logic [CLA_W-1:0] S,
    output logic             C4,
    output logic             P_block,
    output logic             G_block
`ifdef CLA_4_BIT_OVF_EN
    ,
    output logic             OVF
`endif
);

    logic [CLA_W-1:0] p;
    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] c;
    logic [CLA_W-1:0] sum_d;
    logic             c4_d;
    cla_block_pg_t    blk;

    for (genvar i = 0; i < CLA_W; i++) begin : g_pg
        cla_pg_cell u_pg (
            .a(A[i]),
            .b(B[i]),
            .p(p[i]),
            .g(g[i])
        );
    end

    // Flat two-level lookahead: every carry is a sum of products of P/G and C0.
    always_comb begin
        c    = '0;
        c[0] = C0;
        c[1] = g[0] | (p[0] & C0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & C0);
        blk   = cla_block_pg(p, g);
        c4_d  = blk.g_block | (blk.p_block & C0);
        sum_d = p ^ c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            S       <= '0;
            C4      <= 1'b0;
            P_block <= 1'b0;
            G_block <= 1'b0;
        end else begin
            S       <= sum_d;
            C4      <= c4_d;
            P_block <= blk.p_block;
            G_block <= blk.g_block;
        end
    end

`ifdef CLA_4_BIT_OVF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OVF <= 1'b0;
        end else begin
            OVF <= c4_d ^ c[3];
        end
    end
`endif

endmodule

// File: tb/tb_cla_4_bit.sv
// Self-checking bench for cla_4_bit: arithmetic reference model plus directed vectors.
module tb_cla_4_bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       C0;
    logic [3:0] S;
    logic       C4;
    logic       P_block;
    logic       G_block;
`ifdef CLA_4_BIT_OVF_EN
    logic       OVF;
`endif

    int errors = 0;
    int checks = 0;

    cla_4_bit dut (
        .clk(clk),
        .rst_n(rst_n),
        .A(A),
        .B(B),
        .C0(C0),
        .S(S),
        .C4(C4),
        .P_block(P_block),
        .G_block(G_block)
`ifdef CLA_4_BIT_OVF_EN
        ,
        .OVF(OVF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: plain integer arithmetic on the previous edge's inputs.
    int  exp_s, exp_c4, exp_p, exp_g, exp_ovf;
    bit  model_valid = 0;

    always @(posedge clk) begin
        int total, sa, sb, ssum;
        total = int'(A) + int'(B) + int'(C0);
        sa    = (A > 7) ? int'(A) - 16 : int'(A);
        sb    = (B > 7) ? int'(B) - 16 : int'(B);
        ssum  = sa + sb + int'(C0);
        if (!rst_n) begin
            exp_s <= 0; exp_c4 <= 0; exp_p <= 0; exp_g <= 0; exp_ovf <= 0;
        end else begin
            exp_s   <= total % 16;
            exp_c4  <= (total > 15) ? 1 : 0;
            exp_p   <= ((A ^ B) == 4'hF) ? 1 : 0;
            exp_g   <= ((int'(A) + int'(B)) > 15) ? 1 : 0;
            exp_ovf <= (ssum > 7 || ssum < -8) ? 1 : 0;
        end
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_S", int'(S), exp_s);
            check("model_C4", int'(C4), exp_c4);
            check("model_P_block", int'(P_block), exp_p);
            check("model_G_block", int'(G_block), exp_g);
`ifdef CLA_4_BIT_OVF_EN
            check("model_OVF", int'(OVF), exp_ovf);
`endif
        end
    end

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c, input logic r);
        A     = a;
        B     = b;
        C0    = c;
        rst_n = r;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string name, input int s, input int c4, input int pb, input int gb);
        check({name, "_S"}, int'(S), s);
        check({name, "_C4"}, int'(C4), c4);
        check({name, "_P"}, int'(P_block), pb);
        check({name, "_G"}, int'(G_block), gb);
    endtask

    initial begin
        rst_n = 1'b0;
        A = '0; B = '0; C0 = 1'b0;

        apply(4'd9, 4'd9, 1'b1, 1'b0);
        apply(4'd9, 4'd9, 1'b1, 1'b0);
        expect4("reset", 0, 0, 0, 0);

        apply(4'd3, 4'd5, 1'b0, 1'b1);
        expect4("3p5", 8, 0, 0, 0);
        apply(4'd7, 4'd9, 1'b0, 1'b1);
        expect4("7p9", 0, 1, 0, 1);
        apply(4'd15, 4'd1, 1'b0, 1'b1);
        expect4("15p1", 0, 1, 0, 1);
        apply(4'd4, 4'd6, 1'b1, 1'b1);
        check("4p6c_S", int'(S), 11);
        check("4p6c_C4", int'(C4), 0);
        apply(4'd8, 4'd8, 1'b1, 1'b1);
        expect4("8p8c", 1, 1, 0, 1);
        apply(4'd15, 4'd0, 1'b1, 1'b1);
        expect4("15p0c", 0, 1, 1, 0);
        apply(4'd15, 4'd0, 1'b0, 1'b1);
        expect4("15p0", 15, 0, 1, 0);

        apply(4'd15, 4'd15, 1'b1, 1'b0);
        expect4("midrst", 0, 0, 0, 0);
        apply(4'd15, 4'd15, 1'b1, 1'b1);
        expect4("postrst", 15, 1, 0, 1);

`ifdef CLA_4_BIT_OVF_EN
        apply(4'd7, 4'd1, 1'b0, 1'b1);
        check("ovf_7p1", int'(OVF), 1);
        apply(4'd8, 4'd8, 1'b0, 1'b1);
        check("ovf_8p8", int'(OVF), 1);
        apply(4'd3, 4'd5, 1'b0, 1'b1);
        check("ovf_3p5", int'(OVF), 1);
        apply(4'd2, 4'd1, 1'b0, 1'b1);
        check("ovf_2p1", int'(OVF), 0);
`endif

        for (int unsigned a = 0; a < 16; a++) begin
            for (int unsigned b = 0; b < 16; b++) begin
                for (int unsigned c = 0; c < 2; c++) begin
                    apply(4'(a), 4'(b), 1'(c), 1'b1);
                end
            end
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
